// File: rtl/track_seq_ctrl_if.sv
// Purpose: signal bundle between the track countdown sequencer and its parent/renderer.
// Latency: none, wires only.
// Backpressure: none; start is a one-cycle request, abort a level, pause (TRACK_SEQ_PAUSE_EN) a level.
//
// Optional feature macro: TRACK_SEQ_PAUSE_EN adds the pause input.
// Signals:
//   start         parent -> seq : one-cycle sequence request
//   abort         parent -> seq : level, forces IDLE
//   pix_index     driver -> seq : current OLED pixel index (0..6143)
//   pause         parent -> seq : level, freezes frame ticks (TRACK_SEQ_PAUSE_EN only)
//   count         seq -> renderer : digit select (0="3" .. 3="0")
//   y_pos         seq -> renderer : glyph top row
//   visible       seq -> parent   : renderer colour enable
//   busy          seq -> parent   : sequence in progress
//   done          seq -> parent   : one-cycle completion pulse
interface track_seq_ctrl_if;
  logic        start;
  logic        abort;
  logic [12:0] pix_index;
`ifdef TRACK_SEQ_PAUSE_EN
  logic        pause;
`endif
  logic [1:0]  count;
  logic [6:0]  y_pos;
  logic        visible;
  logic        busy;
  logic        done;

`ifdef TRACK_SEQ_PAUSE_EN
  modport master (
    output start, abort, pix_index, pause,
    input  count, y_pos, visible, busy, done
  );
  modport slave (
    input  start, abort, pix_index, pause,
    output count, y_pos, visible, busy, done
  );
`else
  modport master (
    output start, abort, pix_index,
    input  count, y_pos, visible, busy, done
  );
  modport slave (
    input  start, abort, pix_index,
    output count, y_pos, visible, busy, done
  );
`endif
endinterface

// File: rtl/track_seq_ctrl.sv
// Purpose: frame-aligned sequencer for the ingredient-track countdown overlay (3-2-1-0, then glyph drop).
// Latency: start -> busy/visible one clk; a frame-tick decision lands on count/y_pos/done one clk later.
// Backpressure: none; start ignored while busy, abort overrides everything, pause (TRACK_SEQ_PAUSE_EN) masks frame ticks.
//
// Optional feature macro: TRACK_SEQ_PAUSE_EN (adds bus.pause; default build has no pause).
// Ports:
//   clk    in : single clock domain
//   rst_n  in : synchronous, active-low reset
//   bus    slave modport of track_seq_ctrl_if:
//            in  start, abort, pix_index[12:0], pause (macro only)
//            out count[1:0], y_pos[6:0], visible, busy, done (all registered)
module track_seq_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 30,  // 1..255
  parameter int unsigned Y_START         = 10,
  parameter int unsigned Y_END           = 40   // Y_START <= Y_END <= 59
) (
  input  logic             clk,
  input  logic             rst_n,
  track_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_DROP      = 2'd2
  } state_e;

  localparam logic [7:0] FCNT_LAST   = 8'(FRAMES_PER_STEP - 1);
  localparam logic [6:0] Y_START_C   = 7'(Y_START);
  localparam logic [6:0] Y_END_C     = 7'(Y_END);
  localparam logic [1:0] COUNT_LAST  = 2'd3;

  state_e      state_q, state_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [12:0] pix_q;
  logic [1:0]  count_q, count_d;
  logic [6:0]  y_pos_q, y_pos_d;
  logic        visible_q, visible_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        ftick_raw;
  logic        ftick;

  // ---------------------------------------------------------------------------
  // Frame tick: the first clk on which pix_index reads 0 after being non-zero.
  // Comparing against the registered previous index (rather than counting
  // clocks) makes this independent of how long each pixel is held, and a
  // long stall at pixel 0 still produces only one tick.
  // ---------------------------------------------------------------------------
  assign ftick_raw = (bus.pix_index == 13'd0) && (pix_q != 13'd0);

`ifdef TRACK_SEQ_PAUSE_EN
  // A masked tick is simply lost; the frame it belonged to is part of the pause.
  assign ftick = ftick_raw && !bus.pause;
`else
  assign ftick = ftick_raw;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    count_d   = count_q;
    y_pos_d   = y_pos_q;
    visible_d = visible_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (bus.abort) begin
      // Abort beats start and ftick in the same cycle; no done on this path.
      state_d   = ST_IDLE;
      fcnt_d    = 8'd0;
      count_d   = 2'd0;
      y_pos_d   = Y_START_C;
      visible_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d   = ST_COUNTDOWN;
            fcnt_d    = 8'd0;
            count_d   = 2'd0;
            y_pos_d   = Y_START_C;
            visible_d = 1'b1;
            busy_d    = 1'b1;
          end
        end

        ST_COUNTDOWN: begin
          if (ftick) begin
            if (fcnt_q == FCNT_LAST) begin
              fcnt_d = 8'd0;
              if (count_q != COUNT_LAST) begin
                count_d = count_q + 2'd1;
              end else begin
                // "0" has been held for its full step; start sliding.
                state_d = ST_DROP;
              end
            end else begin
              fcnt_d = fcnt_q + 8'd1;
            end
          end
        end

        ST_DROP: begin
          if (ftick) begin
            if (y_pos_q == Y_END_C) begin
              // Glyph has been shown at its final row for one frame.
              done_d    = 1'b1;
              state_d   = ST_IDLE;
              fcnt_d    = 8'd0;
              count_d   = 2'd0;
              y_pos_d   = Y_START_C;
              visible_d = 1'b0;
              busy_d    = 1'b0;
            end else begin
              y_pos_d = y_pos_q + 7'd1;
            end
          end
        end

        default: begin
          state_d   = ST_IDLE;
          fcnt_d    = 8'd0;
          count_d   = 2'd0;
          y_pos_d   = Y_START_C;
          visible_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      fcnt_q    <= 8'd0;
      pix_q     <= 13'd0;
      count_q   <= 2'd0;
      y_pos_q   <= Y_START_C;
      visible_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      pix_q     <= bus.pix_index;
      count_q   <= count_d;
      y_pos_q   <= y_pos_d;
      visible_q <= visible_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.y_pos   = y_pos_q;
  assign bus.visible = visible_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  // ---------------------------------------------------------------------------
  // Structural invariants of the sequencer
  // ---------------------------------------------------------------------------
  // The renderer is enabled exactly while a sequence runs.
  a_vis_eq_busy: assert property (@(posedge clk) visible_q == busy_q);

  // done is only raised on the transition back to IDLE.
  a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |-> (!busy_q && state_q == ST_IDLE));

  // done is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |=> !done_q);

  // The glyph never leaves its travel range.
  a_y_range: assert property (@(posedge clk) disable iff (!rst_n)
    (y_pos_q >= Y_START_C) && (y_pos_q <= Y_END_C));

endmodule

// File: tb/tb_track_seq_ctrl.sv
`timescale 1ns/1ps
module tb_track_seq_ctrl;

  localparam int FPS   = 2;
  localparam int YS    = 10;
  localparam int YE    = 13;
  localparam int NPIX  = 8;   // short frames keep the run small; only 0 vs non-zero matters
  localparam int TOTAL = 4*FPS + (YE - YS) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  track_seq_ctrl_if bus();

  track_seq_ctrl #(
    .FRAMES_PER_STEP(FPS),
    .Y_START        (YS),
    .Y_END          (YE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: sequence progress measured in frame ticks since start.
  bit m_busy    = 1'b0;
  int m_n       = 0;
  int m_done    = 0;
  int prev_pix  = 1;
  bit pause_lvl = 1'b0;

`ifdef TRACK_SEQ_PAUSE_EN
  assign bus.pause = pause_lvl;
`endif

  // done pulse monitor
  int done_seen   = 0;
  int done_run    = 0;
  int done_maxrun = 0;
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_seen   <= done_seen + 1;
      done_run    <= done_run + 1;
      done_maxrun <= (done_run + 1 > done_maxrun) ? done_run + 1 : done_maxrun;
    end else begin
      done_run <= 0;
    end
  end

  // ---------------- reference model ----------------
  task automatic m_tick();
    if (m_busy) begin
      m_n++;
      if (m_n == TOTAL) begin
        m_busy = 1'b0;
        m_done++;
      end
    end
  endtask

  function automatic logic [10:0] exp_vec();
    logic [1:0] c;
    logic [6:0] y;
    int         cnt;
    int         yy;
    cnt = 0;
    yy  = YS;
    if (m_busy) begin
      cnt = (m_n < 4*FPS) ? (m_n / FPS) : 3;
      if (m_n >= 4*FPS) yy = YS + (m_n - 4*FPS);
    end
    c = 2'(cnt);
    y = 7'(yy);
    return {c, y, m_busy, m_busy};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame: pixel 0 then pixels 1..NPIX-1, each held a random 1..4 clk.
  task automatic frame();
    if (prev_pix != 0 && !pause_lvl) m_tick();
    bus.pix_index = 13'd0;
    prev_pix      = 0;
    cycles($urandom_range(1, 4));
    for (int p = 1; p < NPIX; p++) begin
      bus.pix_index = 13'(p);
      prev_pix      = p;
      cycles($urandom_range(1, 4));
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    if (!m_busy) begin
      m_busy = 1'b1;
      m_n    = 0;
    end
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    m_busy = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [10:0] got;
    rst_n = 1'b0;
    cycles(3);
    settle();
    got = {bus.count, bus.y_pos, bus.visible, bus.busy};
    n_assert++;
    if (got !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_state: {count,y,vis,busy} got=%h exp=%h", got, exp_vec());
    end
    n_assert++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got=%b exp=0", bus.done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame();
      settle();
      got = {bus.count, bus.y_pos, bus.visible, bus.busy};
      n_assert++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL idle_frame%0d: got=%h exp=%h", i, got, exp_vec());
      end
      n_assert++;
      if (done_seen !== m_done) begin
        n_fail++;
        $display("FAIL idle_done%0d: done pulses got=%0d exp=%0d", i, done_seen, m_done);
      end
    end
  endtask

  task automatic test_full_seq();
    logic [10:0] got;
    pulse_start();
    settle();
    n_assert++;
    if (bus.busy !== 1'b1 || bus.visible !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: busy=%b visible=%b exp 1/1", bus.busy, bus.visible);
    end
    for (int i = 0; i < TOTAL + 2; i++) begin
      frame();
      settle();
      got = {bus.count, bus.y_pos, bus.visible, bus.busy};
      n_assert++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL full_seq_tick%0d: got=%h exp=%h", i, got, exp_vec());
      end
      n_assert++;
      if (done_seen !== m_done) begin
        n_fail++;
        $display("FAIL full_seq_done%0d: pulses got=%0d exp=%0d", i, done_seen, m_done);
      end
    end
    n_assert++;
    if (done_maxrun !== 1) begin
      n_fail++;
      $display("FAIL done_width: longest pulse got=%0d exp=1", done_maxrun);
    end
  endtask

  task automatic test_abort();
    logic [10:0] got;
    pulse_start();
    while (m_n < 5) frame();
    pulse_abort();
    settle();
    got = {bus.count, bus.y_pos, bus.visible, bus.busy};
    n_assert++;
    if (got !== exp_vec()) begin
      n_fail++;
      $display("FAIL abort_idle: got=%h exp=%h", got, exp_vec());
    end
    for (int i = 0; i < TOTAL; i++) begin
      frame();
      settle();
      got = {bus.count, bus.y_pos, bus.visible, bus.busy};
      n_assert++;
      if (got !== exp_vec() || done_seen !== m_done) begin
        n_fail++;
        $display("FAIL abort_after%0d: got=%h exp=%h done got=%0d exp=%0d",
                 i, got, exp_vec(), done_seen, m_done);
      end
    end
  endtask

  task automatic test_abort_collisions();
    logic [10:0] got;
    pulse_start();
    for (int i = 0; i < TOTAL - 1; i++) frame();
    settle();
    got = {bus.count, bus.y_pos, bus.visible, bus.busy};
    n_assert++;
    if (got !== exp_vec()) begin
      n_fail++;
      $display("FAIL drop_last_row: got=%h exp=%h", got, exp_vec());
    end
    // abort held over the frame whose tick would have finished the sequence
    m_busy    = 1'b0;
    bus.abort = 1'b1;
    frame();
    bus.abort = 1'b0;
    settle();
    got = {bus.count, bus.y_pos, bus.visible, bus.busy};
    n_assert++;
    if (got !== exp_vec() || done_seen !== m_done) begin
      n_fail++;
      $display("FAIL abort_vs_ftick: got=%h exp=%h done got=%0d exp=%0d",
               got, exp_vec(), done_seen, m_done);
    end
    // start and abort together stay idle
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    settle();
    n_assert++;
    if (bus.busy !== 1'b0 || bus.visible !== 1'b0) begin
      n_fail++;
      $display("FAIL start_vs_abort: busy=%b visible=%b exp 0/0", bus.busy, bus.visible);
    end
  endtask

  task automatic test_start_while_busy();
    logic [10:0] got;
    pulse_start();
    for (int i = 0; i < 3; i++) frame();
    pulse_start();   // model ignores: already busy
    for (int i = 0; i < TOTAL; i++) begin
      frame();
      settle();
      got = {bus.count, bus.y_pos, bus.visible, bus.busy};
      n_assert++;
      if (got !== exp_vec() || done_seen !== m_done) begin
        n_fail++;
        $display("FAIL busy_start%0d: got=%h exp=%h done got=%0d exp=%0d",
                 i, got, exp_vec(), done_seen, m_done);
      end
    end
    // back-to-back: restart immediately after completion
    pulse_start();
    for (int i = 0; i < TOTAL + 1; i++) begin
      frame();
      settle();
      got = {bus.count, bus.y_pos, bus.visible, bus.busy};
      n_assert++;
      if (got !== exp_vec() || done_seen !== m_done) begin
        n_fail++;
        $display("FAIL back_to_back%0d: got=%h exp=%h done got=%0d exp=%0d",
                 i, got, exp_vec(), done_seen, m_done);
      end
    end
  endtask

  task automatic test_zero_hold();
    logic [10:0] got;
    pulse_start();
    m_tick();
    bus.pix_index = 13'd0;
    prev_pix      = 0;
    cycles(100);
    settle();
    got = {bus.count, bus.y_pos, bus.visible, bus.busy};
    n_assert++;
    if (got !== exp_vec()) begin
      n_fail++;
      $display("FAIL zero_hold: got=%h exp=%h", got, exp_vec());
    end
    for (int p = 1; p < 6144; p++) begin
      bus.pix_index = 13'(p);
      cycles(1);
    end
    prev_pix = 6143;
    frame();
    settle();
    got = {bus.count, bus.y_pos, bus.visible, bus.busy};
    n_assert++;
    if (got !== exp_vec()) begin
      n_fail++;
      $display("FAIL zero_hold_sweep: got=%h exp=%h", got, exp_vec());
    end
    for (int i = 0; i < TOTAL; i++) frame();
    settle();
    n_assert++;
    if (done_seen !== m_done || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_hold_end: done got=%0d exp=%0d busy=%b", done_seen, m_done, bus.busy);
    end
  endtask

  task automatic test_reset_mid_seq();
    logic [10:0] got;
    pulse_start();
    for (int i = 0; i < 5; i++) frame();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    m_busy = 1'b0;
    settle();
    got = {bus.count, bus.y_pos, bus.visible, bus.busy};
    n_assert++;
    if (got !== exp_vec() || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got=%h exp=%h done=%b", got, exp_vec(), bus.done);
    end
    for (int i = 0; i < 3; i++) frame();
    settle();
    n_assert++;
    if (done_seen !== m_done) begin
      n_fail++;
      $display("FAIL reset_mid_done: got=%0d exp=%0d", done_seen, m_done);
    end
  endtask

  task automatic test_random();
    logic [10:0] got;
    int          r;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 15);
      if (r < 3)       pulse_start();
      else if (r == 3) pulse_abort();
      frame();
      settle();
      got = {bus.count, bus.y_pos, bus.visible, bus.busy};
      n_assert++;
      if (got !== exp_vec() || done_seen !== m_done) begin
        n_fail++;
        $display("FAIL random%0d: got=%h exp=%h done got=%0d exp=%0d",
                 i, got, exp_vec(), done_seen, m_done);
      end
    end
  endtask

`ifdef TRACK_SEQ_PAUSE_EN
  task automatic test_pause();
    logic [10:0] got;
    pulse_start();
    while (m_n < 2) frame();
    pause_lvl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame();
      settle();
      got = {bus.count, bus.y_pos, bus.visible, bus.busy};
      n_assert++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL pause_hold%0d: got=%h exp=%h", i, got, exp_vec());
      end
    end
    pause_lvl = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      frame();
      settle();
      got = {bus.count, bus.y_pos, bus.visible, bus.busy};
      n_assert++;
      if (got !== exp_vec() || done_seen !== m_done) begin
        n_fail++;
        $display("FAIL pause_resume%0d: got=%h exp=%h done got=%0d exp=%0d",
                 i, got, exp_vec(), done_seen, m_done);
      end
    end
    // start still accepted in IDLE while paused
    pause_lvl = 1'b1;
    pulse_start();
    settle();
    n_assert++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_start: busy got=%b exp=1", bus.busy);
    end
    pulse_abort();
    pause_lvl = 1'b0;
  endtask
`endif

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.pix_index = 13'd1;
    test_reset();
    test_full_seq();
    test_abort();
    test_abort_collisions();
    test_start_while_busy();
    test_zero_hold();
    test_reset_mid_seq();
`ifdef TRACK_SEQ_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
